// File: rtl/eclair_mul_pkg.sv
// Shared constants, types and the exact 10u x 16s -> 26s product helper
// for the ECLAIR multiplier scheduler.
package eclair_mul_pkg;

  localparam int unsigned MUL_A_W  = 10;
  localparam int unsigned MUL_B_W  = 16;
  localparam int unsigned MUL_P_W  = 26;
  localparam int unsigned MUL_NREQ = 4;
  localparam int unsigned MUL_IDW  = $clog2(MUL_NREQ);

  typedef logic [MUL_IDW-1:0]        mul_tag_t;
  typedef logic signed [MUL_P_W-1:0] mul_prod_t;

  // A is zero-extended and B sign-extended, so the 26-bit product is exact.
  function automatic mul_prod_t mul_prod(input logic [MUL_A_W-1:0]        a,
                                         input logic signed [MUL_B_W-1:0] b);
    mul_prod_t ae;
    mul_prod_t be;
    ae = mul_prod_t'({1'b0, a});
    be = mul_prod_t'(b);
    return ae * be;
  endfunction

endpackage

// File: rtl/eclair_mul_rr_arb.sv
// Round-robin arbiter: grants one requester per enabled cycle, searching
// upward from rrptr with wrap, and advances rrptr past the granted lane.
module eclair_mul_rr_arb
  import eclair_mul_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] rrptr_q;
  logic [IDW-1:0] rrptr_d;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(rrptr_q) + i) % NREQ);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  // A grant is always a transfer because it is only issued to a valid lane.
  always_comb begin
    rrptr_d = rrptr_q;
    if (found) begin
      rrptr_d = IDW'((32'(gnt_id) + 1) % NREQ);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rrptr_q <= '0;
    end else begin
      rrptr_q <= rrptr_d;
    end
  end

endmodule

// File: rtl/eclair_mul_share_sched.sv
// Time-shares one 10u x 16s multiplier between NREQ requesters with a
// LAT-deep stallable valid/tag/product pipe and a single tagged response.
module eclair_mul_share_sched
  import eclair_mul_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*MUL_A_W-1:0] req_a,
  input  logic [NREQ*MUL_B_W-1:0] req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [MUL_P_W-1:0]      rsp_data,
  input  logic                    rsp_ready
);

  logic                       adv;
  logic                       xfer;
  logic [NREQ-1:0]            gnt;
  logic [IDW-1:0]             gnt_id;
  logic [MUL_A_W-1:0]         a_sel;
  logic signed [MUL_B_W-1:0]  b_sel;
  mul_prod_t                  p_new;

  logic [LAT-1:0]             v_q;
  logic [IDW-1:0]             id_q [LAT];
  mul_prod_t                  p_q  [LAT];

  // The whole pipe moves together; a held last stage freezes everything.
  assign adv = !v_q[LAT-1] || rsp_ready;

  eclair_mul_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .req      (req_valid),
    .en       (adv),
    .gnt      (gnt),
    .gnt_id   (gnt_id)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    a_sel = req_a[MUL_A_W*gnt_id +: MUL_A_W];
    b_sel = req_b[MUL_B_W*gnt_id +: MUL_B_W];
    p_new = mul_prod(a_sel, b_sel);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        id_q[i] <= '0;
        p_q[i]  <= '0;
      end
    end else if (adv) begin
      v_q[0] <= xfer;
      if (xfer) begin
        id_q[0] <= gnt_id;
        p_q[0]  <= p_new;
      end
      for (int unsigned i = 1; i < LAT; i++) begin
        v_q[i]  <= v_q[i-1];
        id_q[i] <= id_q[i-1];
        p_q[i]  <= p_q[i-1];
      end
    end
  end

  assign rsp_valid = v_q[LAT-1];
  assign rsp_id    = id_q[LAT-1];
  assign rsp_data  = p_q[LAT-1];

endmodule
